// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - multi-cycle issue controller driving a register-file + ALU datapath
// Decodes R-type/LI/NOP/HALT words and sequences read, ALU capture and write-back.
module datapath_sequencer #(
  parameter int Nloc  = 32,
  parameter int Dbits = 32,
  parameter int Abits = $clog2(Nloc)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              RegWrite,
  output logic [Abits-1:0]  ReadAddr1,
  output logic [Abits-1:0]  ReadAddr2,
  output logic [Abits-1:0]  WriteAddr,
  output logic [4:0]        ALUFN,
  output logic [Dbits-1:0]  WriteData,
  input  logic [Dbits-1:0]  ALUResult,
  input  logic              FlagZ,
  output logic              busy,
  output logic              halted,
  output logic              zero,
  output logic [15:0]       retired
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]       r_state;
  logic             r_live;
  logic [Abits-1:0] r_rd;
  logic [Abits-1:0] r_ra1;
  logic [Abits-1:0] r_ra2;
  logic [Abits-1:0] r_wa;
  logic [4:0]       r_alufn;
  logic [Dbits-1:0] r_result;
  logic             r_zero;
  logic [15:0]      r_retired;

  logic             w_accept;
  logic [Dbits-1:0] w_imm;
  logic             w_unused_bits;

  assign w_unused_bits = &{1'b0, instr[9:0]};
  assign w_imm         = {{(Dbits-25){instr[24]}}, instr[24:0]};

  // r_live keeps ready low for the whole reset and until the first edge after release
  assign instr_ready = (r_state == S_IDLE) && r_live;
  assign w_accept    = instr_valid && instr_ready;

  // Gating with reset_n stops the register file writing on an aborting reset edge
  assign RegWrite  = (r_state == S_WB) && reset_n;
  assign busy      = (r_state != S_IDLE);
  assign halted    = (r_state == S_HALT);
  assign ReadAddr1 = r_ra1;
  assign ReadAddr2 = r_ra2;
  assign ALUFN     = r_alufn;
  assign WriteAddr = r_wa;
  assign WriteData = r_result;
  assign zero      = r_zero;
  assign retired   = r_retired;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_live    <= 1'b0;
      r_rd      <= '0;
      r_ra1     <= '0;
      r_ra2     <= '0;
      r_wa      <= '0;
      r_alufn   <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (instr[31:30])
              2'b00: begin
                r_rd    <= instr[29:25];
                r_ra1   <= instr[24:20];
                r_ra2   <= instr[19:15];
                r_alufn <= instr[14:10];
                r_state <= S_EXEC;
              end
              2'b01: begin
                r_wa     <= instr[29:25];
                r_result <= w_imm;
                r_state  <= S_WB;
              end
              2'b10: r_retired <= r_retired + 16'd1;
              default: begin
                r_retired <= r_retired + 16'd1;
                r_state   <= S_HALT;
              end
            endcase
          end
        end
        S_EXEC: begin
          r_wa     <= r_rd;
          r_result <= ALUResult;
          r_zero   <= FlagZ;
          r_state  <= S_WB;
        end
        S_WB: begin
          r_retired <= r_retired + 16'd1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - directed bench for datapath_sequencer
// A behavioural register file + ALU stands in for the datapath; writes are checked against a queue.
module tb_datapath_sequencer;

  localparam logic [4:0] FN_ADD = 5'b00001;
  localparam logic [4:0] FN_SUB = 5'b10001;

  logic        clock;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        RegWrite;
  logic [4:0]  ReadAddr1;
  logic [4:0]  ReadAddr2;
  logic [4:0]  WriteAddr;
  logic [4:0]  ALUFN;
  logic [31:0] WriteData;
  logic [31:0] ALUResult;
  logic        FlagZ;
  logic        busy;
  logic        halted;
  logic        zero;
  logic [15:0] retired;

  datapath_sequencer #(.Nloc(32), .Dbits(32)) dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .RegWrite(RegWrite), .ReadAddr1(ReadAddr1),
    .ReadAddr2(ReadAddr2), .WriteAddr(WriteAddr), .ALUFN(ALUFN), .WriteData(WriteData),
    .ALUResult(ALUResult), .FlagZ(FlagZ), .busy(busy), .halted(halted), .zero(zero),
    .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Datapath stand-in
  logic [31:0] rf [32];
  always @(posedge clock) if (RegWrite) rf[WriteAddr] <= WriteData;
  always_comb begin
    ALUResult = rf[ReadAddr1];
    case (ALUFN)
      FN_ADD:  ALUResult = rf[ReadAddr1] + rf[ReadAddr2];
      FN_SUB:  ALUResult = rf[ReadAddr1] - rf[ReadAddr2];
      default: ALUResult = rf[ReadAddr1];
    endcase
  end
  assign FlagZ = (ALUResult == 32'd0);

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: {write address, write data}
  logic [36:0] q[$];
  logic [36:0] mon_e;
  logic [31:0] sh [32];
  logic        exp_zero;
  logic [15:0] exp_ret;
  int          last_acc;
  int          last_wr;

  always begin
    @(negedge clock);
    #4;
    if (RegWrite === 1'b1) begin
      if (q.size() == 0) chk("unexpected_write", {27'd0, WriteAddr}, 32'hFFFFFFFF);
      else begin
        mon_e = q.pop_front();
        chk("wb_addr", {27'd0, WriteAddr}, {27'd0, mon_e[36:32]});
        chk("wb_data", WriteData, mon_e[31:0]);
      end
      last_wr = cyc + 1;
    end
  end

  function automatic logic [31:0] r_ins(input logic [4:0] rd, rs, rt, fn);
    return {2'b00, rd, rs, rt, fn, 10'h2A5};
  endfunction
  function automatic logic [31:0] li_ins(input logic [4:0] rd, input logic [24:0] imm);
    return {2'b01, rd, imm};
  endfunction
  localparam logic [31:0] NOP_W  = {2'b10, 30'h155};
  localparam logic [31:0] HALT_W = {2'b11, 30'h0};

  task automatic push_r(input logic [4:0] rd, rs, rt, fn);
    logic [31:0] v;
    v = (fn == FN_ADD) ? sh[rs] + sh[rt] : sh[rs] - sh[rt];
    sh[rd] = v;
    exp_zero = (v == 32'd0);
    q.push_back({rd, v});
  endtask
  task automatic push_li(input logic [4:0] rd, input logic [31:0] v);
    sh[rd] = v;
    q.push_back({rd, v});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && n < 16) begin
      @(negedge clock);
      n++;
    end
    chk("send_ready_timeout", {31'd0, n < 16}, 32'd1);
    @(posedge clock);
    #1 last_acc = cyc;
    @(negedge clock);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 32) begin
      @(negedge clock);
      n++;
    end
    chk("drain_timeout", q.size(), 32'd0);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_regwrite"}, {31'd0, RegWrite}, 32'd0);
    chk({p, "_ra1"}, {27'd0, ReadAddr1}, 32'd0);
    chk({p, "_ra2"}, {27'd0, ReadAddr2}, 32'd0);
    chk({p, "_wa"}, {27'd0, WriteAddr}, 32'd0);
    chk({p, "_alufn"}, {27'd0, ALUFN}, 32'd0);
    chk({p, "_wd"}, WriteData, 32'd0);
    chk({p, "_busy"}, {31'd0, busy}, 32'd0);
    chk({p, "_halted"}, {31'd0, halted}, 32'd0);
    chk({p, "_zero"}, {31'd0, zero}, 32'd0);
    chk({p, "_retired"}, {16'd0, retired}, 32'd0);
    chk({p, "_ready"}, {31'd0, instr_ready}, 32'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int first_acc;
    for (int i = 0; i < 32; i++) begin rf[i] = 32'd0; sh[i] = 32'd0; end
    exp_zero = 1'b0;
    exp_ret  = 16'd0;
    reset_n = 1'b0; instr = 32'd0; instr_valid = 1'b0;
    repeat (3) @(negedge clock);
    check_zero("rst");
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);

    // Load and add, streamed back to back
    push_li(5'd1, 32'd5);  send(li_ins(5'd1, 25'd5)); first_acc = last_acc;
    push_li(5'd2, 32'd3);  send(li_ins(5'd2, 25'd3));
    push_r(5'd3, 5'd1, 5'd2, FN_ADD); send(r_ins(5'd3, 5'd1, 5'd2, FN_ADD));
    drain();
    exp_ret += 16'd3;
    chk("add_retired", {16'd0, retired}, {16'd0, exp_ret});
    chk("add_zero", {31'd0, zero}, {31'd0, exp_zero});
    chk("add_cycles_incl", last_wr - first_acc + 1, 32'd7);

    // Subtract, negative then zero
    push_r(5'd4, 5'd2, 5'd1, FN_SUB); send(r_ins(5'd4, 5'd2, 5'd1, FN_SUB));
    drain();
    chk("sub_neg_zero", {31'd0, zero}, 32'd0);
    push_r(5'd5, 5'd1, 5'd1, FN_SUB); send(r_ins(5'd5, 5'd1, 5'd1, FN_SUB));
    drain();
    chk("sub_self_zero", {31'd0, zero}, 32'd1);
    exp_ret += 16'd2;

    // Sign extension; LI must leave zero untouched
    push_li(5'd6, 32'hFFFFFFF0); send(li_ins(5'd6, 25'h1FFFFF0));
    push_li(5'd7, 32'h00FFFFFF); send(li_ins(5'd7, 25'h0FFFFFF));
    drain();
    exp_ret += 16'd2;
    chk("li_zero_held", {31'd0, zero}, 32'd1);
    chk("li_retired", {16'd0, retired}, {16'd0, exp_ret});

    // Backpressure: only the word at the ready edge executes
    chk("bp_ready0", {31'd0, instr_ready}, 32'd1);
    push_r(5'd9, 5'd6, 5'd7, FN_ADD);
    instr = r_ins(5'd9, 5'd6, 5'd7, FN_ADD); instr_valid = 1'b1;
    @(negedge clock);
    chk("bp_ready1", {31'd0, instr_ready}, 32'd0);
    chk("bp_busy_exec", {31'd0, busy}, 32'd1);
    instr = r_ins(5'd10, 5'd1, 5'd1, FN_ADD);
    @(negedge clock);
    chk("bp_ready2", {31'd0, instr_ready}, 32'd0);
    instr = li_ins(5'd11, 25'h77);
    @(negedge clock);
    chk("bp_ready3", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b0;
    drain();
    exp_ret += 16'd1;
    chk("bp_retired", {16'd0, retired}, {16'd0, exp_ret});
    chk("bp_zero", {31'd0, zero}, {31'd0, exp_zero});

    // Halt is sticky; a held R-type is never accepted
    send(HALT_W);
    exp_ret += 16'd1;
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_retired", {16'd0, retired}, {16'd0, exp_ret});
    instr = r_ins(5'd12, 5'd1, 5'd2, FN_ADD); instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("halt_ready", {31'd0, instr_ready}, 32'd0);
    end
    chk("halt_still", {31'd0, halted}, 32'd1);
    instr_valid = 1'b0;

    reset_n = 1'b0;
    @(negedge clock);
    check_zero("rst2");
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset2", {31'd0, instr_ready}, 32'd1);

    // Reset during WB aborts the write
    send(li_ins(5'd8, 25'h1234));
    chk("abort_in_wb", {31'd0, RegWrite}, 32'd1);
    #2 reset_n = 1'b0;
    @(negedge clock);
    check_zero("abort");

    // NOP stream from reset wraps retired
    instr = NOP_W; instr_valid = 1'b1; reset_n = 1'b1;
    @(negedge clock);
    chk("nop_start", {16'd0, retired}, 32'd0);
    chk("nop_ready", {31'd0, instr_ready}, 32'd1);
    repeat (65535) @(negedge clock);
    chk("nop_ffff", {16'd0, retired}, 32'h0000FFFF);
    @(negedge clock);
    chk("nop_wrap", {16'd0, retired}, 32'd0);
    chk("nop_not_busy", {31'd0, busy}, 32'd0);
    instr_valid = 1'b0;
    @(negedge clock);
    chk("queue_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
